td4p_core: RTL

- Parametrised next-generation 4-bit-style accumulator CPU core: same A/B/carry/IP/OUT register model and opcode map, generalised to DATA_W-bit data and ADDR_W-bit program address.
- Fetches instructions over a ready/request handshake, so program memory can insert wait states.
- Adds halt, a run enable, an output-update strobe and a "jc" jump.
- Sits between program ROM/RAM and board switch/LED I/O.

---
 rtl/td4p_pkg.sv | 45 ++++
 rtl/td4p_alu.sv | 64 ++++++
 rtl/td4p_core.sv | 139 +++++++++++++
 3 files changed

// File: rtl/td4p_pkg.sv
// Shared types for the td4p accumulator core: opcode map, FSM states and
// the jump-resolution helper used by the ALU.
package td4p_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD_A     = 4'b0000,
    OP_MOV_A_B   = 4'b0001,
    OP_IN_A      = 4'b0010,
    OP_MOV_A_IMM = 4'b0011,
    OP_MOV_B_A   = 4'b0100,
    OP_ADD_B     = 4'b0101,
    OP_IN_B      = 4'b0110,
    OP_MOV_B_IMM = 4'b0111,
    OP_NOP       = 4'b1000,
    OP_OUT_B     = 4'b1001,
    OP_OUT_A     = 4'b1010,
    OP_OUT_IMM   = 4'b1011,
    OP_HALT      = 4'b1100,
    OP_JC        = 4'b1101,
    OP_JNC       = 4'b1110,
    OP_JMP       = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_e;

  // True when the instruction redirects IP to its immediate, given the pre-EXEC carry.
  function automatic logic takes_jump(input opcode_e op, input logic cf);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JNC:  taken = ~cf;
      OP_JC:   taken = cf;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/td4p_alu.sv
// Combinational execute stage: next A/B/CF, OUT write and jump decision
// for the instruction currently held in IR.
module td4p_alu
  import td4p_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  opcode_e             opcode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W-1:0]   imm,
  input  logic [DATA_W-1:0]   io_in,
  input  logic                cf,
  output logic [DATA_W-1:0]   next_a,
  output logic [DATA_W-1:0]   next_b,
  output logic                next_cf,
  output logic                out_we,
  output logic [DATA_W-1:0]   out_val,
  output logic                jump_taken
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum_a;
  logic [SUM_W-1:0] sum_b;

  // Carry-out lands in the top bit of the widened sums.
  assign sum_a = SUM_W'(a) + SUM_W'(imm);
  assign sum_b = SUM_W'(b) + SUM_W'(imm);

  assign jump_taken = takes_jump(opcode, cf);

  always_comb begin
    next_a  = a;
    next_b  = b;
    next_cf = 1'b0;
    out_we  = 1'b0;
    out_val = '0;
    case (opcode)
      OP_ADD_A:     {next_cf, next_a} = sum_a;
      OP_ADD_B:     {next_cf, next_b} = sum_b;
      OP_MOV_A_IMM: next_a = imm;
      OP_MOV_B_IMM: next_b = imm;
      OP_MOV_A_B:   next_a = b;
      OP_MOV_B_A:   next_b = a;
      OP_IN_A:      next_a = io_in;
      OP_IN_B:      next_b = io_in;
      OP_OUT_B: begin
        out_we  = 1'b1;
        out_val = b;
      end
      OP_OUT_A: begin
        out_we  = 1'b1;
        out_val = a;
      end
      OP_OUT_IMM: begin
        out_we  = 1'b1;
        out_val = imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/td4p_core.sv
// td4p accumulator core: fetch/exec/halt sequencer, IP and architectural
// registers, with a request/ready instruction fetch port.
module td4p_core
  import td4p_pkg::*;
#(
  parameter  int unsigned DATA_W  = 4,
  parameter  int unsigned ADDR_W  = 4,
  localparam int unsigned INSTR_W = OPC_W + DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic [DATA_W-1:0]  io_in,
  output logic [DATA_W-1:0]  io_out,
  output logic               io_out_strobe,
  output logic               halted
);

  state_e              state_q;
  state_e              state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                cf_q;
  logic [ADDR_W-1:0]   ip_q;
  logic [DATA_W-1:0]   out_q;
  logic                strobe_q;
  logic                halted_q;

  logic                ir_we;
  logic                exec_en;
  opcode_e             opcode;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   ip_inc;
  logic [ADDR_W-1:0]   ip_next;

  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic                alu_cf;
  logic                alu_out_we;
  logic [DATA_W-1:0]   alu_out_val;
  logic                alu_jump;

  assign opcode = opcode_e'(ir_q[INSTR_W-1 -: OPC_W]);
  assign imm    = ir_q[DATA_W-1:0];

  td4p_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode     (opcode),
    .a          (a_q),
    .b          (b_q),
    .imm        (imm),
    .io_in      (io_in),
    .cf         (cf_q),
    .next_a     (alu_a),
    .next_b     (alu_b),
    .next_cf    (alu_cf),
    .out_we     (alu_out_we),
    .out_val    (alu_out_val),
    .jump_taken (alu_jump)
  );

  // Jump targets are zero-extended or truncated to the address width by the cast.
  assign ip_inc = ip_q + ADDR_W'(1);

  always_comb begin
    ip_next = ip_inc;
    if (opcode == OP_HALT) begin
      ip_next = ip_q;
    end else if (alu_jump) begin
      ip_next = ADDR_W'(imm);
    end
  end

  // Next-state and fetch handshake; the request is qualified by reset so a
  // fetch in a reset cycle is abandoned.
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    ir_we   = 1'b0;
    exec_en = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = run & reset;
        if (mem_req && mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = (opcode == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cf_q     <= 1'b0;
      ip_q     <= '0;
      out_q    <= '0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      strobe_q <= exec_en & alu_out_we;
      if (ir_we) begin
        ir_q <= mem_data;
      end
      if (exec_en) begin
        a_q  <= alu_a;
        b_q  <= alu_b;
        cf_q <= alu_cf;
        ip_q <= ip_next;
        if (alu_out_we) begin
          out_q <= alu_out_val;
        end
      end
    end
  end

  assign mem_addr      = ip_q;
  assign io_out        = out_q;
  assign io_out_strobe = strobe_q;
  assign halted        = halted_q;

endmodule
